// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit : multi-cycle RV32M divider (DIV / DIVU / REM / REMU)
//
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// clock, followed by a single sign fix-up cycle. Latency is fixed at
// XLEN+1 edges from the accepting edge to the done pulse.
//
// Ports
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   start  : request, sampled only while idle
//   op     : 00 DIV, 01 DIVU, 10 REM, 11 REMU (latched with start)
//   a, b   : dividend / divisor (latched with start)
//   flush  : synchronous abort of an in-flight operation
//   busy   : operation in progress (stall the pipeline)
//   done   : one-cycle pulse, result valid
//   result : quotient or remainder, held until the next completion
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int XLEN = 32,
  parameter int CNTW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_op;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;   // holds |a| at start; dividend bits shift out as quotient bits shift in
  logic [XLEN-1:0]   r_div;
  logic [CNTW-1:0]   r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  // ---------------------------------------------------------------------------
  // Operand capture (evaluated on the raw inputs in IDLE)
  // ---------------------------------------------------------------------------
  logic            w_is_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_b_nz;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;

  assign w_is_signed = ~op[0];
  assign w_a_neg     = w_is_signed & a[XLEN-1];
  assign w_b_neg     = w_is_signed & b[XLEN-1];
  assign w_b_nz      = |b;
  // Most-negative value negates to itself; as an unsigned magnitude that is
  // still correct, which is what makes the overflow case fall out naturally.
  assign w_a_mag     = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag     = w_b_neg ? (~b + 1'b1) : b;

  // ---------------------------------------------------------------------------
  // Restoring step
  // ---------------------------------------------------------------------------
  // The shifted partial remainder needs XLEN+1 bits: rem < |b| can be as large
  // as 2^XLEN-2, so after the shift it may exceed XLEN bits.
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;

  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_div});
  // When w_ge holds the true difference is < |b|, so XLEN bits suffice.
  assign w_diff   = w_rem_sh[XLEN-1:0] - r_div;
  assign w_rem_nx = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
  assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};

  // ---------------------------------------------------------------------------
  // Sign fix-up
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_res;

  assign w_rem_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;
  assign w_quo_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_res     = r_op[1] ? w_rem_fix : w_quo_fix;

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          // flush beats a simultaneous start
          if (start && !flush) begin
            r_op    <= op;
            // A zero divisor must yield all-ones, so the quotient sign is
            // suppressed rather than flipping it to 1.
            r_neg_q <= w_is_signed & (a[XLEN-1] ^ b[XLEN-1]) & w_b_nz;
            r_neg_r <= w_a_neg;
            r_quo   <= w_a_mag;
            r_div   <= w_b_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end

        S_CALC: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == {CNTW{1'b1}}) r_state <= S_FINISH;
          end
        end

        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (!flush) begin
            r_result <= w_res;
            r_done   <= 1'b1;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative divider; the inverse of the ALU's multiply path.
- Implements RV32M DIV, DIVU, REM and REMU, which the single-cycle ALU does not compute.
- Sits beside the ALU in the execute stage. The control path issues a start pulse with operands and stalls the pipeline while busy is high.
- Radix-2 restoring algorithm on operand magnitudes, followed by a sign fix-up cycle.

Parameters:
- XLEN, 32, operand/result width in bits.
- CNTW, 5, iteration counter width; must satisfy 2^CNTW = XLEN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; latched with start.
- a  input  XLEN  dividend; latched with start.
- b  input  XLEN  divisor; latched with start.
- flush  input  1  synchronous abort from pipeline flush.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result is valid.
- result  output  XLEN  quotient or remainder, held until the next completion.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, busy=0, done=0, result=0, all internal registers cleared. Applies at any time, including mid-operation; no partial result is ever presented.
- States: IDLE, CALC, FINISH.
- IDLE:
  - done is cleared every cycle unless FINISH sets it.
  - On start=1 at edge E0: latch op; is_signed = ~op[0]; neg_q = is_signed & (a[31]^b[31]) & (b!=0); neg_r = is_signed & a[31].
  - Latch |a| and |b|: two's-complement negation when is_signed and the sign bit is set; otherwise the raw value. Clear remainder and count. Go to CALC, busy=1.
- CALC: one restoring step per edge, E1..E32.
  - Shift {rem,quo} left 1, bringing in the dividend MSB.
  - If rem >= |b|: rem -= |b| and quotient bit = 1.
  - When count==31, go to FINISH.
- FINISH (edge E33):
  - result = op[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo).
  - done=1, busy=0, go to IDLE.
- Latency: done is high in the cycle after E33, i.e. 33 edges after start is accepted. Latency is fixed and independent of operand values; no early-out.
- Divide by zero arises from the algorithm unaided:
  - Quotient = 0xFFFFFFFF. Negation is suppressed by the b!=0 term.
  - Remainder = a, signed or unsigned.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. This arises from 32-bit wrap of the magnitude; no special logic.
- start while busy=1: ignored; operands and op are not relatched.
- start in the cycle done=1: accepted (state is IDLE). Back-to-back issue is therefore possible with no bubble beyond the done cycle.
- flush=1 in CALC or FINISH: next state IDLE, busy=0, done stays 0, result unchanged.
- flush=1 together with start in IDLE: flush wins; nothing is accepted.
- flush has no effect in IDLE otherwise.
- result changes only at FINISH or reset.
- busy is registered; it is high from the edge after E0 through E33.

Test Plan:
- DIV a=0xFFFFFFF9 (-7), b=2 → after 33 edges done=1, result=0xFFFFFFFD (-3); REM on the same operands → 0xFFFFFFFF (-1).
- DIVU a=0xFFFFFFFF, b=0x10 → result=0x0FFFFFFF; REMU on the same operands → 0x0000000F.
- Divide by zero, a=5, b=0: DIV → 0xFFFFFFFF; DIVU → 0xFFFFFFFF; REM → 5; REMU → 5.
- Overflow, a=0x80000000, b=0xFFFFFFFF: DIV → 0x80000000; REM → 0.
- Pulse start again with new operands at cycle 10 while busy → ignored, first result unchanged. Then assert start with REMU 100/7 on the done cycle → accepted; done 33 edges later with result=2.
- Assert rst at cycle 15 of an operation → busy=0, done=0, result=0 immediately. Assert flush at cycle 20 → busy=0 next edge, no done pulse, result keeps its previous value.
